// File: rtl/math_arb_pkg.sv
// Shared encodings for the math unit arbiter: op codes, FSM states, default watchdog limit.
package math_arb_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/math_unit_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    j   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      j = sum[IW-1:0];
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/math_unit_arbiter.sv
// Round-robin arbiter sharing one multiplier and one divider among NREQ requesters, one op in flight.
// Optional watchdog on ISSUE/WAIT enabled by MATH_ARB_TIMEOUT_EN.
module math_unit_arbiter
  import math_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 32,
  parameter int MWIDTH      = 16,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       op_i,
  input  logic [NREQ*WIDTH-1:0] a_i,
  input  logic [NREQ*WIDTH-1:0] b_i,
  output logic [NREQ-1:0]       ack_o,
  output logic [WIDTH-1:0]      result_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  mul_stb_o,
  output logic [MWIDTH-1:0]     mul_a_o,
  output logic [MWIDTH-1:0]     mul_b_o,
  input  logic                  mul_busy_i,
  input  logic                  mul_done_i,
  input  logic [2*MWIDTH-1:0]   mul_p_i,
  output logic                  div_start_o,
  output logic [WIDTH-1:0]      div_a_o,
  output logic [WIDTH-1:0]      div_b_o,
  input  logic                  div_busy_i,
  input  logic                  div_done_i,
  input  logic                  div_valid_i,
  input  logic                  div_dbz_i,
  input  logic                  div_ovf_i,
  input  logic [WIDTH-1:0]      div_val_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || WIDTH < 2*MWIDTH || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("math_unit_arbiter: illegal parameter combination");
  end

  logic [NREQ-1:0][WIDTH-1:0] a_v, b_v;
  assign a_v = a_i;
  assign b_v = b_i;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, gnt_idx_q;
  logic [NREQ-1:0]   gnt_oh_q;
  logic              op_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic              err_q;

  logic [NREQ-1:0]   pk_gnt;
  logic [IW-1:0]     pk_idx;
  logic              pk_any;

  logic              cap_en, cap_err;
  logic [WIDTH-1:0]  cap_res;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (pk_gnt),
    .idx (pk_idx),
    .any (pk_any)
  );

`ifdef MATH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          cnt_q <= '0;
    else if (state_q == ST_IDLE)                         cnt_q <= '0;
    else if (state_q == ST_ISSUE || state_q == ST_WAIT)  cnt_q <= cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d     = state_q;
    mul_stb_o   = 1'b0;
    div_start_o = 1'b0;
    cap_en      = 1'b0;
    cap_res     = '0;
    cap_err     = 1'b0;
    case (state_q)
      ST_IDLE:  if (pk_any) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (op_q == OP_DIV ? !div_busy_i : !mul_busy_i) begin
          mul_stb_o   = (op_q == OP_MUL);
          div_start_o = (op_q == OP_DIV);
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // only the selected unit's done is honoured
        if (op_q == OP_MUL && mul_done_i) begin
          cap_en  = 1'b1;
          cap_res = WIDTH'(mul_p_i);
          state_d = ST_RESP;
        end else if (op_q == OP_DIV && div_done_i) begin
          cap_en  = 1'b1;
          cap_res = div_val_i;
          cap_err = div_dbz_i | div_ovf_i | ~div_valid_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
`ifdef MATH_ARB_TIMEOUT_EN
    // a real completion in the limit cycle wins over the watchdog
    if ((state_q == ST_ISSUE || state_q == ST_WAIT) && !cap_en &&
        cnt_q == CW'(TIMEOUT_CYC - 1)) begin
      state_d     = ST_RESP;
      mul_stb_o   = 1'b0;
      div_start_o = 1'b0;
      cap_en      = 1'b1;
      cap_res     = '0;
      cap_err     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pk_any) begin
        gnt_idx_q <= pk_idx;
        gnt_oh_q  <= pk_gnt;
        op_q      <= op_i[pk_idx];
        a_q       <= a_v[pk_idx];
        b_q       <= b_v[pk_idx];
      end
      if (cap_en) begin
        res_q <= cap_res;
        err_q <= cap_err;
      end
      if (state_q == ST_RESP)
        ptr_q <= (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
    end
  end

  assign ack_o    = (state_q == ST_RESP) ? gnt_oh_q : '0;
  assign result_o = res_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign mul_a_o  = a_q[MWIDTH-1:0];
  assign mul_b_o  = b_q[MWIDTH-1:0];
  assign div_a_o  = a_q;
  assign div_b_o  = b_q;

endmodule

// File: tb/tb_math_unit_arbiter.sv
// Directed bench for math_unit_arbiter with behavioural multiplier and Q16.16 divider models.
module tb_math_unit_arbiter;
  import math_arb_pkg::*;

  localparam int NREQ = 4, WIDTH = 32, MWIDTH = 16;
`ifdef MATH_ARB_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = 255;
`endif
  localparam int MLAT = 3, DLAT = 5;

  logic clk, rst_n;
  logic [NREQ-1:0] req_i, op_i, ack_o;
  logic [NREQ*WIDTH-1:0] a_i, b_i;
  logic [WIDTH-1:0] result_o, div_a_o, div_b_o, div_val_i;
  logic err_o, busy_o, mul_stb_o, mul_busy_i, mul_done_i;
  logic [MWIDTH-1:0] mul_a_o, mul_b_o;
  logic [2*MWIDTH-1:0] mul_p_i;
  logic div_start_o, div_busy_i, div_done_i, div_valid_i, div_dbz_i, div_ovf_i;

  math_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MWIDTH(MWIDTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .ack_o(ack_o), .result_o(result_o), .err_o(err_o), .busy_o(busy_o),
    .mul_stb_o(mul_stb_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_busy_i(mul_busy_i), .mul_done_i(mul_done_i), .mul_p_i(mul_p_i),
    .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_busy_i(div_busy_i), .div_done_i(div_done_i), .div_valid_i(div_valid_i),
    .div_dbz_i(div_dbz_i), .div_ovf_i(div_ovf_i), .div_val_i(div_val_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // multiplier model: signed MWIDTH x MWIDTH, MLAT cycles busy then a done pulse
  logic [7:0] mcnt;
  logic signed [MWIDTH-1:0] ma, mb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_busy_i <= 1'b0; mul_done_i <= 1'b0; mcnt <= '0; mul_p_i <= '0; ma <= '0; mb <= '0;
    end else begin
      mul_done_i <= 1'b0;
      if (mul_stb_o && !mul_busy_i) begin
        mul_busy_i <= 1'b1; mcnt <= 8'(MLAT); ma <= mul_a_o; mb <= mul_b_o;
      end else if (mul_busy_i) begin
        mcnt <= mcnt - 1'b1;
        if (mcnt == 8'd1) begin
          mul_busy_i <= 1'b0; mul_done_i <= 1'b1;
          mul_p_i <= 32'($signed(ma) * $signed(mb));
        end
      end
    end
  end

  // divider model: Q16.16 signed quotient, dhang keeps it busy forever
  logic dhang = 1'b0;
  logic [7:0] dcnt;
  logic [WIDTH-1:0] da, db;
  logic signed [63:0] dq;
  logic dq_ovf;
  assign dq = (db == '0) ? 64'sd0 :
              $signed({{16{da[31]}}, da, 16'h0}) / $signed({{32{db[31]}}, db});
  assign dq_ovf = !((&dq[63:31]) || !(|dq[63:31]));
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy_i <= 1'b0; div_done_i <= 1'b0; dcnt <= '0; da <= '0; db <= '0;
      div_val_i <= '0; div_valid_i <= 1'b0; div_dbz_i <= 1'b0; div_ovf_i <= 1'b0;
    end else begin
      div_done_i <= 1'b0;
      if (div_start_o && !div_busy_i) begin
        div_busy_i <= 1'b1; dcnt <= 8'(DLAT); da <= div_a_o; db <= div_b_o;
      end else if (div_busy_i && !dhang) begin
        dcnt <= dcnt - 1'b1;
        if (dcnt == 8'd1) begin
          div_busy_i  <= 1'b0; div_done_i <= 1'b1;
          div_dbz_i   <= (db == '0);
          div_ovf_i   <= dq_ovf;
          div_valid_i <= !(db == '0) && !dq_ovf;
          div_val_i   <= dq[31:0];
        end
      end
    end
  end

  int mstb_n = 0, dstb_n = 0;
  logic multi_ack = 1'b0;
  always @(negedge clk) begin
    if (mul_stb_o)   mstb_n <= mstb_n + 1;
    if (div_start_o) dstb_n <= dstb_n + 1;
    if ($countones(ack_o) > 1) multi_ack <= 1'b1;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic op, input logic [31:0] a, input logic [31:0] b);
    a_i[k*WIDTH +: WIDTH] = a;
    b_i[k*WIDTH +: WIDTH] = b;
    op_i[k]  = op;
    req_i[k] = 1'b1;
  endtask

  task automatic wait_ack(input string tag, input int k, input logic [31:0] er,
                          input logic ee, input bit chk_res);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (ack_o == '0 && n < 300);
    chk({tag, "_ack"}, 32'(ack_o), 32'(1 << k));
    if (chk_res) chk({tag, "_res"}, result_o, er);
    chk({tag, "_err"}, 32'(err_o), 32'(ee));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ack"},  32'(ack_o), 32'h0);
    chk({tag, "_res"},  result_o, 32'h0);
    chk({tag, "_err"},  32'(err_o), 32'h0);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_stb"},  32'({mul_stb_o, div_start_o}), 32'h0);
    chk({tag, "_opnd"}, div_a_o | div_b_o | 32'({mul_a_o, mul_b_o}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int m0, d0, n;
    int exp_k[5];
    logic [31:0] exp_r[5];
    logic seen;
    rst_n = 1'b0; req_i = '0; op_i = '0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1 chk_zero_outputs("rst");
    rst_n = 1'b1;

    // multiply: -5100 * -500
    set_req(0, OP_MUL, 32'h0000EC14, 32'h0000FE0C);
    wait_ack("mul0", 0, 32'h0026E8F0, 1'b0, 1);
    chk("mul0_opa", 32'(mul_a_o), 32'h0000EC14);
    req_i = '0;
    @(posedge clk); #1;
    chk("mul0_pulse", 32'(ack_o), 32'h0);
    chk("mul0_hold", result_o, 32'h0026E8F0);

    // divide 128.0 / 15.0; operand change after grant must be ignored
    set_req(1, OP_DIV, 32'h00800000, 32'h000F0000);
    @(posedge clk); #1;
    a_i[1*WIDTH +: WIDTH] = 32'h12345678;
    wait_ack("div1", 1, 32'h00088888, 1'b0, 1);
    req_i = '0;

    // divide by zero
    set_req(2, OP_DIV, 32'h00010000, 32'h0);
    wait_ack("dbz2", 2, 32'h0, 1'b1, 0);
    req_i = '0;

    // reset during WAIT of a divide: immediate clear, no ack afterwards
    set_req(3, OP_DIV, 32'h00010000, 32'h00010000);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!div_busy_i && n < 20);
    chk("rstw_inwait", 32'(busy_o), 32'h1);
    rst_n = 1'b0;
    #1 chk_zero_outputs("rstw");
    req_i = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen = seen | (|ack_o); end
    chk("rstw_noack", 32'(seen), 32'h0);

    // all four held, alternating ops: order 0,1,2,3,0 after reset
    m0 = mstb_n; d0 = dstb_n;
    set_req(0, OP_MUL, 32'h00000003, 32'h00000007);
    set_req(1, OP_DIV, 32'h00010000, 32'h00020000);
    set_req(2, OP_MUL, 32'h0000FFFE, 32'h00000003);
    set_req(3, OP_DIV, 32'h000A0000, 32'h00040000);
    exp_k = '{0, 1, 2, 3, 0};
    exp_r = '{32'h15, 32'h8000, 32'hFFFFFFFA, 32'h00028000, 32'h15};
    for (int i = 0; i < 5; i++) begin
      wait_ack($sformatf("rr%0d", i), exp_k[i], exp_r[i], 1'b0, 1);
    end
    req_i = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rr_mstb", 32'(mstb_n - m0), 32'd3);
    chk("rr_dstb", 32'(dstb_n - d0), 32'd2);
    chk("rr_multi", 32'(multi_ack), 32'h0);
    chk("rr_idle", 32'(busy_o), 32'h0);

`ifdef MATH_ARB_TIMEOUT_EN
    // hung divider: watchdog responds TMO cycles after ISSUE entry
    dhang = 1'b1;
    set_req(1, OP_DIV, 32'h00010000, 32'h00010000);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!busy_o && n < 20);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ack_o == '0 && n < 100);
    req_i = '0;
    chk("tmo_lat", 32'(n), 32'(TMO));
    chk("tmo_ack", 32'(ack_o), 32'h2);
    chk("tmo_err", 32'(err_o), 32'h1);
    chk("tmo_res", result_o, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/math_unit_arbiter.md
Name: math_unit_arbiter

Overview:
- Shares one multi-cycle multiplier (slowmpy-style strobe/busy/done interface) and one fixed-point divider (div-style start/busy/done/valid interface) between NREQ requesters.
- Requesters include the sprite/physics logic, the UART command decoder and future geometry stages.
- Round-robin arbitration; exactly one operation in flight at a time.
- Routes operands to the selected unit and returns the result, with error flags, to the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, divider operand/result width and result bus width.
- MWIDTH, 16, multiplier operand width; must satisfy WIDTH >= 2*MWIDTH.
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NREQ  per-requester request level
- op_i  in  NREQ  per-requester op: 0 = multiply, 1 = divide
- a_i  in  NREQ*WIDTH  packed operand A; requester k uses slice [k*WIDTH +: WIDTH]
- b_i  in  NREQ*WIDTH  packed operand B; same slicing as a_i
- ack_o  out  NREQ  one-cycle completion pulse to the granted requester
- result_o  out  WIDTH  result, valid while ack_o is nonzero
- err_o  out  1  error, valid with ack_o: dbz, ovf, div invalid, or timeout
- busy_o  out  1  high whenever the FSM is not IDLE
- mul_stb_o  out  1  multiplier start strobe
- mul_a_o  out  MWIDTH  multiplier operand A
- mul_b_o  out  MWIDTH  multiplier operand B
- mul_busy_i  in  1  multiplier busy
- mul_done_i  in  1  multiplier done
- mul_p_i  in  2*MWIDTH  multiplier product
- div_start_o  out  1  divider start
- div_a_o  out  WIDTH  divider operand A
- div_b_o  out  WIDTH  divider operand B
- div_busy_i  in  1  divider busy
- div_done_i  in  1  divider done
- div_valid_i  in  1  divider result valid
- div_dbz_i  in  1  divider divide-by-zero flag
- div_ovf_i  in  1  divider overflow flag
- div_val_i  in  WIDTH  divider result

Behaviour:
- Reset (async, rst_n low): state IDLE; ack_o=0, result_o=0, err_o=0, busy_o=0, mul_stb_o=0, div_start_o=0, all operand outputs 0, rr pointer=0, grant register=0.
  - Reset mid-operation abandons the op; no ack is issued.
  - The downstream units share the same system reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_i bit is set, pick the first set bit at or after the rr pointer, wrapping at NREQ.
  - Latch the grant index, op, and both operands (mul uses the low MWIDTH bits of A and B) → ISSUE.
- ISSUE:
  - Wait until the selected unit's busy input is 0.
  - Then assert mul_stb_o or div_start_o for exactly one cycle → WAIT.
  - Operand outputs hold the latched values from ISSUE until RESP.
- WAIT:
  - Multiply: on mul_done_i, capture result_o = mul_p_i zero-extended to WIDTH (signed product bits unchanged), err=0.
  - Divide: on div_done_i, capture result_o = div_val_i, err = div_dbz_i | div_ovf_i | ~div_valid_i.
  - After capture → RESP.
  - A done from the non-selected unit is ignored.
- RESP:
  - ack_o[grant]=1 for one cycle, with result_o/err_o valid.
  - rr pointer = grant+1, mod NREQ.
  - → IDLE.
  - result_o and err_o hold until the next RESP.
- Latency: req seen in IDLE → ack is 3 cycles plus unit latency plus any busy stall.
- Requester rules:
  - Operands are latched in IDLE, so changes after the grant cycle have no effect.
  - A requester keeping req_i high after its ack re-enters arbitration behind the others.
  - If req_i drops during ISSUE/WAIT, the op still completes and ack is still pulsed; the requester ignores it.
- Fairness: a continuously asserted request is served within NREQ operations.
- Simultaneous requests at reset release: requester 0 wins.
- No-request cycles leave the rr pointer unchanged.

Optional Feature:
- Macro: MATH_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ISSUE and counts during ISSUE and WAIT.
  - Reaching TIMEOUT_CYC forces RESP with err_o=1 and result_o=0.
  - A late done from the abandoned op is ignored; the next ISSUE still waits for that unit's busy to clear.
- Undefined: no counter; the FSM waits indefinitely in ISSUE/WAIT.

Decomposition:
- Package math_arb_pkg:
  - Op encodings OP_MUL=1'b0, OP_DIV=1'b1.
  - FSM state encodings ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP.
  - Default TIMEOUT_CYC.
- Sub-module rr_picker:
  - Inputs: NREQ-wide req vector and pointer.
  - Outputs: one-hot grant, binary index, any-valid.
  - Purely combinational; the pointer register stays in math_unit_arbiter.

Test Plan:
- Req0 multiply, a=16'hEC14 (-5100), b=16'hFE0C (-500) → ack_o[0] pulse, result_o=32'h0026E8F0, err_o=0.
- Req1 divide, a=32'h00800000 (128.0), b=32'h000F0000 (15.0), Q16.16 → ack_o[1], result_o=32'h00088888, err_o=0.
- Req2 divide by b=0 → ack_o[2], err_o=1.
- All four req held high with alternating ops → acks arrive in order 0,1,2,3,0; exactly one mul_stb_o/div_start_o pulse per op; no two acks in the same cycle.
- rst_n pulsed low during WAIT of a divide → all outputs 0 immediately; no ack; the next request is served normally.
- With MATH_ARB_TIMEOUT_EN, TIMEOUT_CYC=20, divider model never asserts done → ack at 20 cycles after ISSUE entry, err_o=1, result_o=0.
